hpf_frame_sequencer: RTL
========================

// Module: hpf_frame_sequencer
// PURPOSE
// Sequences the G.729 pre-processing high-pass filter. Accepts raw 16-bit
// samples over a valid/ready stream, presents each one to the filter and pulses
// its clock enable once per sample. Writes the filtered output into a ping-pong
// frame buffer of two FRAME_LEN banks and hands completed frames to the
// encoder with a valid/ack handshake. Sits between the audio front end and the
// LPC analysis stage.
// PARAMETERS
// FRAME_LEN  80   samples per frame (10 ms at 8 kHz); must be <= 2**IDX_W
// IDX_W      7    width of the in-frame sample index
// DW         16   sample width
// PORTS
// clk          in   1        system clock, rising edge
// rst_n        in   1        asynchronous active-low reset
// enable       in   1        1 = accept samples; 0 = halt after current sample
// s_valid      in   1        input sample valid
// s_data       in   DW       input sample, two's complement
// s_ready      out  1        block accepts s_data this cycle
// hpf_x        out  DW       filter input (drives audio_in)
// hpf_ce       out  1        filter clock enable, one pulse per sample
// hpf_y        in   DW       filter output (pre_proc_audio), combinational
// buf_we       out  1        frame-buffer write strobe
// buf_addr     out  IDX_W+1  {bank, index}
// buf_wdata    out  DW       filtered sample to store
// frame_valid  out  1        a completed frame is available in frame_bank
// frame_bank   out  1        bank holding the oldest completed frame
// frame_ack    in   1        encoder has consumed frame_bank (1-cycle pulse)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, idx=0, wr_bank=0, rd_bank=0,
//   full[1:0]=0, x_reg=0. Outputs: hpf_x=0, hpf_ce=0, buf_we=0, buf_addr=0,
//   buf_wdata=0, s_ready=0, frame_valid=0, frame_bank=0. Reset mid-frame
//   discards the partial frame. The filter's internal state is not reset here.
// - FSM states: IDLE, FILT. Outputs are decoded from registered state only.
// - IDLE: s_ready = enable & ~full[wr_bank]. On s_valid & s_ready:
//   x_reg <= s_data, go to FILT. Otherwise stay in IDLE.
// - FILT (exactly 1 cycle): hpf_ce=1, buf_we=1, buf_addr={wr_bank,idx},
//   buf_wdata=hpf_y. s_ready=0. Return to IDLE.
//   - If idx==FRAME_LEN-1: idx<=0, full[wr_bank]<=1, wr_bank toggles.
//   - Otherwise: idx<=idx+1.
// - hpf_x = x_reg at all times; it changes only on acceptance. The filter state
//   advances only on the hpf_ce cycle. Throughput: 1 sample per 2 cycles.
//   Latency: sample accepted at cycle N is written at cycle N+1.
// - frame_valid = full[rd_bank]; frame_bank = rd_bank.
// - frame_ack while frame_valid=1: full[rd_bank] <= 0, rd_bank toggles.
//   frame_ack while frame_valid=0 is ignored.
// - Frame completion and frame_ack in the same cycle both take effect (they
//   touch different banks). The freed bank may be accepted into on the next
//   cycle.
// - Both banks full: s_ready=0 (backpressure). No sample is dropped or
//   overwritten.
// - enable=0 during FILT: the current sample completes, then the block holds in
//   IDLE with idx preserved. Re-enable resumes at the same address.
// - Widths: idx wraps only via the FRAME_LEN-1 compare, never by overflow.
//   No arithmetic is performed on the sample data.
// TESTING
// 1 Reset; 80 back-to-back samples of 16'd1000 -> 80 buf_we pulses at addr
//   0..79 on alternate cycles; frame_valid=1, frame_bank=0 in the cycle after
//   the 80th write.
// 2 160 samples with no ack -> both banks full, s_ready=0. Then ack -> next
//   cycle frame_bank=1 and s_ready=1; the next write goes to addr {0,0}.
// 3 enable=0 after sample 40 -> s_ready=0 and no writes. Re-enable -> the next
//   write goes to addr {0,40}.
// 4 frame_ack pulse while frame_valid=0 -> full, rd_bank and frame_bank are
//   unchanged.
// 5 rst_n low during sample 30 of bank 1 -> all outputs 0 immediately. After
//   release, the first write goes to addr {0,0}.
// 6 The 80th write of bank 1 coincides with an ack of bank 0 -> full becomes
//   2'b10, frame_bank=1, and s_ready=1 on the following cycle.

Source files
------------

// File: rtl/hpf_frame_sequencer.sv
// Sequencer for the pre-processing high-pass filter. It takes one raw sample,
// holds it on the filter input, pulses the filter clock enable once, and stores
// the filtered result in a two-bank ping-pong frame buffer. Completed frames are
// handed to the encoder through a valid/ack handshake.
//
// state | meaning
// IDLE  | waiting for a sample; s_ready is high when a free bank is open
// FILT  | filter enabled for one cycle, filtered sample written to the buffer
module hpf_frame_sequencer #(
  parameter int FRAME_LEN = 80,
  parameter int IDX_W     = 7,
  parameter int DW        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             s_valid,
  input  logic [DW-1:0]    s_data,
  output logic             s_ready,
  output logic [DW-1:0]    hpf_x,
  output logic             hpf_ce,
  input  logic [DW-1:0]    hpf_y,
  output logic             buf_we,
  output logic [IDX_W:0]   buf_addr,
  output logic [DW-1:0]    buf_wdata,
  output logic             frame_valid,
  output logic             frame_bank,
  input  logic             frame_ack
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, FILT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             wr_bank, wr_bank_nxt;
  logic             rd_bank, rd_bank_nxt;
  logic [1:0]       full, full_nxt;
  logic [DW-1:0]    x_reg, x_nxt;

  // State and datapath registers; reset drops any partially written frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      x_reg   <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      wr_bank <= wr_bank_nxt;
      rd_bank <= rd_bank_nxt;
      full    <= full_nxt;
      x_reg   <= x_nxt;
    end
  end

  // Next-state and output decode. Frame completion and frame consumption touch
  // different banks, so both updates are applied to full_nxt independently.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    wr_bank_nxt = wr_bank;
    rd_bank_nxt = rd_bank;
    full_nxt    = full;
    x_nxt       = x_reg;
    s_ready     = 1'b0;
    hpf_ce      = 1'b0;
    buf_we      = 1'b0;
    buf_addr    = '0;
    buf_wdata   = '0;

    case (state)
      IDLE: begin
        // Gated by rst_n so the handshake stays closed while reset is held.
        s_ready = rst_n & enable & ~full[wr_bank];
        if (s_valid && s_ready) begin
          x_nxt     = s_data;
          state_nxt = FILT;
        end
      end
      FILT: begin
        hpf_ce    = 1'b1;
        buf_we    = 1'b1;
        buf_addr  = {wr_bank, idx};
        buf_wdata = hpf_y;
        state_nxt = IDLE;
        if (idx == LAST_IDX) begin
          idx_nxt           = '0;
          full_nxt[wr_bank] = 1'b1;
          wr_bank_nxt       = ~wr_bank;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (frame_ack && full[rd_bank]) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = ~rd_bank;
    end
  end

  assign hpf_x       = x_reg;
  assign frame_valid = full[rd_bank];
  assign frame_bank  = rd_bank;

endmodule
